// File: rtl/dual_ram_be_clr_pkg.sv
// Shared definitions for the byte-enabled dual-port RAM and its clear engine.
package dual_ram_be_clr_pkg;

   localparam logic STATE_IDLE  = 1'b0;
   localparam logic STATE_CLEAR = 1'b1;

   // One-hot array write select driven by the clear engine
   localparam logic [1:0] SEL_NONE  = 2'b00;
   localparam logic [1:0] SEL_USER  = 2'b01;
   localparam logic [1:0] SEL_CLEAR = 2'b10;

   function automatic int num_lanes(input int data_w, input int byte_w);
      return data_w / byte_w;
   endfunction

endpackage

// File: rtl/dual_ram_be_clr_ram_clear_fsm.sv
// Address-walking clear engine: zeroes one word per w_clk, then opens the
// array to user writes and reports that initialisation has completed.
module ram_clear_fsm
   import dual_ram_be_clr_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int MEM_SIZE   = 32
) (
   input  logic                  w_clk,
   input  logic                  w_rst,
   input  logic                  clear_req_i,
   input  logic                  wclken_i,
   output logic [ADDR_WIDTH-1:0] clr_ptr_o,
   output logic [1:0]            wr_sel_o,
   output logic                  wr_ready_o,
   output logic                  init_done_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(MEM_SIZE - 1);

   logic                  state_q,     state_d;
   logic [ADDR_WIDTH-1:0] clr_ptr_q,   clr_ptr_d;
   logic                  wr_ready_q,  wr_ready_d;
   logic                  init_done_q, init_done_d;

   // State register
   always_ff @(posedge w_clk or negedge w_rst) begin
      if (!w_rst) begin
         state_q     <= STATE_CLEAR;
         clr_ptr_q   <= '0;
         wr_ready_q  <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         wr_ready_q  <= wr_ready_d;
         init_done_q <= init_done_d;
      end
   end

   // Next-state logic; a clear request during a pass is ignored
   always_comb begin
      state_d     = state_q;
      clr_ptr_d   = clr_ptr_q;
      wr_ready_d  = wr_ready_q;
      init_done_d = init_done_q;
      case (state_q)
         STATE_CLEAR: begin
            if (clr_ptr_q == LAST_PTR) begin
               state_d     = STATE_IDLE;
               clr_ptr_d   = '0;
               wr_ready_d  = 1'b1;
               init_done_d = 1'b1;
            end else begin
               clr_ptr_d   = clr_ptr_q + ADDR_WIDTH'(1);
            end
         end
         STATE_IDLE: begin
            if (clear_req_i) begin
               state_d    = STATE_CLEAR;
               clr_ptr_d  = '0;
               wr_ready_d = 1'b0;
            end else begin
               state_d    = STATE_IDLE;
            end
         end
         default: begin
            state_d    = STATE_CLEAR;
            clr_ptr_d  = '0;
            wr_ready_d = 1'b0;
         end
      endcase
   end

   // Output logic: array write-port mux select
   always_comb begin
      wr_sel_o = SEL_NONE;
      case (state_q)
         STATE_CLEAR: wr_sel_o = SEL_CLEAR;
         STATE_IDLE: begin
            if (wclken_i) begin
               wr_sel_o = SEL_USER;
            end else begin
               wr_sel_o = SEL_NONE;
            end
         end
         default: wr_sel_o = SEL_NONE;
      endcase
   end

   assign clr_ptr_o   = clr_ptr_q;
   assign wr_ready_o  = wr_ready_q;
   assign init_done_o = init_done_q;

endmodule

// File: rtl/dual_ram_be_clr.sv
// Simple-dual-port RAM with per-byte write enables, optional registered read
// and a word-per-cycle clear engine instead of a resettable array.
module dual_ram_be_clr
   import dual_ram_be_clr_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BYTE_W     = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int MEM_SIZE   = 32,
   parameter int READ_REG   = 1
) (
   input  logic                                        w_clk,
   input  logic                                        w_rst,
   input  logic                                        r_clk,
   input  logic                                        r_rst,
   input  logic                                        wclken,
   input  logic [num_lanes(DATA_WIDTH, BYTE_W)-1:0]    wbe,
   input  logic [ADDR_WIDTH-1:0]                       waddr,
   input  logic [DATA_WIDTH-1:0]                       wrdata,
   input  logic                                        clear_req,
   output logic                                        wr_ready,
   output logic                                        init_done,
   input  logic                                        rclken,
   input  logic [ADDR_WIDTH-1:0]                       raddr,
   output logic [DATA_WIDTH-1:0]                       rdata
);

   localparam int                  NB      = num_lanes(DATA_WIDTH, BYTE_W);
   localparam logic [ADDR_WIDTH:0] MEM_END = (ADDR_WIDTH + 1)'(MEM_SIZE);

   logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
   logic [ADDR_WIDTH-1:0] clr_ptr_s;
   logic [1:0]            wr_sel_s;
   logic                  waddr_ok_s;
   logic                  raddr_ok_s;
   logic [DATA_WIDTH-1:0] rd_word_s;

   assign waddr_ok_s = ({1'b0, waddr} < MEM_END);
   assign raddr_ok_s = ({1'b0, raddr} < MEM_END);

   ram_clear_fsm #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_SIZE   (MEM_SIZE)
   ) u_clear_fsm (
      .w_clk       (w_clk),
      .w_rst       (w_rst),
      .clear_req_i (clear_req),
      .wclken_i    (wclken),
      .clr_ptr_o   (clr_ptr_s),
      .wr_sel_o    (wr_sel_s),
      .wr_ready_o  (wr_ready),
      .init_done_o (init_done)
   );

   // Array write port: clear engine word write, else byte-lane user write
   always_ff @(posedge w_clk) begin
      if (wr_sel_s == SEL_CLEAR) begin
         mem_q[clr_ptr_s] <= '0;
      end else if ((wr_sel_s == SEL_USER) && waddr_ok_s) begin
         for (int k = 0; k < NB; k++) begin
            if (wbe[k]) begin
               mem_q[waddr][k*BYTE_W +: BYTE_W] <= wrdata[k*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   assign rd_word_s = raddr_ok_s ? mem_q[raddr] : '0;

   generate
      if (READ_REG != 0) begin : g_rd_reg
         logic [DATA_WIDTH-1:0] rdata_q;

         // Registered read, holds when rclken is low
         always_ff @(posedge r_clk or negedge r_rst) begin
            if (!r_rst) begin
               rdata_q <= '0;
            end else if (rclken) begin
               rdata_q <= rd_word_s;
            end else begin
               rdata_q <= rdata_q;
            end
         end

         assign rdata = rdata_q;
      end else begin : g_rd_comb
         assign rdata = rd_word_s;
      end
   endgenerate

endmodule
